// File: rtl/mp3_pkg.sv
// Shared constants and types for the MP3 main-data reservoir write path.
package mp3_pkg;

    localparam logic [10:0] HDR_BYTES       = 11'd4;
    localparam logic [10:0] CRC_BYTES       = 11'd2;
    localparam logic [10:0] SI_BYTES_MONO   = 11'd17;
    localparam logic [10:0] SI_BYTES_STEREO = 11'd32;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        MAIN,
        DONE
    } loader_state_t;

    // Bytes ahead of main data: header, optional CRC, side info.
    function automatic logic [10:0] overhead_bytes(input logic mono, input logic crc_present);
        return HDR_BYTES + (crc_present ? CRC_BYTES : 11'd0)
                         + (mono ? SI_BYTES_MONO : SI_BYTES_STEREO);
    endfunction

endpackage

// File: rtl/byte_serializer.sv
// Byte-to-bit serializer feeding the reservoir FIFO, MSB first, stalled by fifo_full.
module byte_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] byte_in,
    input  logic       fifo_full,
    output logic       load_ok,
    output logic       fifo_din,
    output logic       fifo_wr_en,
    output logic       last_write
);

    logic [7:0] sr_q, sr_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        // A new byte may land while the final bit of the current one is written.
        load_ok    = (bit_cnt_q == 4'd0) || ((bit_cnt_q == 4'd1) && !fifo_full);
        fifo_wr_en = (bit_cnt_q != 4'd0) && !fifo_full && !clear;
        fifo_din   = sr_q[7];
        last_write = fifo_wr_en && (bit_cnt_q == 4'd1);
    end

    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        if (clear) begin
            sr_d      = 8'd0;
            bit_cnt_d = 4'd0;
        end else if (load) begin
            sr_d      = byte_in;
            bit_cnt_d = 4'd8;
        end else if (fifo_wr_en) begin
            sr_d      = {sr_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q      <= 8'd0;
            bit_cnt_q <= 4'd0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/reservoir_loader.sv
// Reservoir FIFO write side: skips frame overhead bytes, serialises main-data bytes to bits.
import mp3_pkg::*;

module reservoir_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [10:0] frame_bytes,
    input  logic        mono,
    input  logic        crc_present,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        fifo_full,
    output logic        fifo_din,
    output logic        fifo_wr_en,
    output logic        frame_done,
    output logic        frame_err,
    output logic        frame_abort,
    output logic [10:0] main_bytes
);

    loader_state_t state_q, state_d;
    logic [10:0]   byte_cnt_q, byte_cnt_d;
    logic [10:0]   frame_len_q, frame_len_d;
    logic [10:0]   ovh_q, ovh_d;
    logic [10:0]   main_bytes_q, main_bytes_d;
    logic          err_q, err_d;
    logic          abort_q, abort_d;

    logic [10:0] new_ovh;
    logic        ser_load_ok;
    logic        last_write;
    logic        accept;
    logic        ser_load;

    assign new_ovh     = overhead_bytes(mono, crc_present);
    assign accept      = byte_valid && byte_ready;
    assign ser_load    = accept && (state_q == MAIN);
    assign frame_done  = (state_q == DONE) && !frame_start;
    assign frame_err   = err_q;
    assign frame_abort = abort_q;
    assign main_bytes  = main_bytes_q;

    byte_serializer u_ser (
        .clk        (clk),
        .rst        (rst),
        .clear      (frame_start),
        .load       (ser_load),
        .byte_in    (byte_in),
        .fifo_full  (fifo_full),
        .load_ok    (ser_load_ok),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .last_write (last_write)
    );

    always_comb begin
        byte_ready = 1'b0;
        if (!frame_start) begin
            case (state_q)
                SKIP:    byte_ready = 1'b1;
                MAIN:    byte_ready = (byte_cnt_q != frame_len_q) && ser_load_ok;
                default: byte_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        frame_len_d  = frame_len_q;
        ovh_d        = ovh_q;
        main_bytes_d = main_bytes_q;
        err_d        = 1'b0;
        abort_d      = 1'b0;
        if (frame_start) begin
            abort_d     = (state_q != IDLE);
            frame_len_d = frame_bytes;
            ovh_d       = new_ovh;
            byte_cnt_d  = 11'd0;
            if (frame_bytes < new_ovh) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = SKIP;
            end
        end else begin
            case (state_q)
                SKIP: begin
                    if (accept) begin
                        byte_cnt_d = byte_cnt_q + 11'd1;
                        if (byte_cnt_q == ovh_q - 11'd1) begin
                            state_d = (frame_len_q == ovh_q) ? DONE : MAIN;
                        end
                    end
                end
                MAIN: begin
                    if (accept) begin
                        byte_cnt_d = byte_cnt_q + 11'd1;
                    end
                    if ((byte_cnt_q == frame_len_q) && last_write) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    main_bytes_d = frame_len_q - ovh_q;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            byte_cnt_q   <= 11'd0;
            frame_len_q  <= 11'd0;
            ovh_q        <= 11'd0;
            main_bytes_q <= 11'd0;
            err_q        <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            frame_len_q  <= frame_len_d;
            ovh_q        <= ovh_d;
            main_bytes_q <= main_bytes_d;
            err_q        <= err_d;
            abort_q      <= abort_d;
        end
    end

endmodule

// File: tb/tb_reservoir_loader.sv
// Scoreboard bench for reservoir_loader: expected bits and frame events queued, monitor compares.
module tb_reservoir_loader;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic [10:0] frame_bytes;
    logic        mono;
    logic        crc_present;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        fifo_full;
    logic        fifo_din;
    logic        fifo_wr_en;
    logic        frame_done;
    logic        frame_err;
    logic        frame_abort;
    logic [10:0] main_bytes;

    reservoir_loader dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .frame_bytes (frame_bytes),
        .mono        (mono),
        .crc_present (crc_present),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .fifo_full   (fifo_full),
        .fifo_din    (fifo_din),
        .fifo_wr_en  (fifo_wr_en),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .frame_abort (frame_abort),
        .main_bytes  (main_bytes)
    );

    // kind: 1 = done, 2 = err, 3 = abort
    typedef struct {
        int kind;
        int mb;
        bit lat;
    } ev_t;

    bit   exp_bits[$];
    ev_t  exp_ev[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_wr_cyc = -10;
    int   wr_count = 0;
    bit   mb_pend = 0;
    int   mb_exp = 0;
    bit   bp_en = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        fifo_full = 0;
        forever begin
            @(posedge clk);
            #1;
            fifo_full = bp_en ? ~fifo_full : 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void push_ev(input int k, input int mb, input bit lat);
        ev_t e;
        e.kind = k;
        e.mb   = mb;
        e.lat  = lat;
        exp_ev.push_back(e);
    endfunction

    task automatic see_ev(input int k);
        ev_t e;
        checks++;
        if (exp_ev.size() == 0) begin
            errors++;
            $display("FAIL event: got kind %0d, none expected", k);
        end else begin
            e = exp_ev.pop_front();
            if (e.kind != k) begin
                errors++;
                $display("FAIL event: got kind %0d, required kind %0d", k, e.kind);
            end else if (k == 1) begin
                mb_pend = 1;
                mb_exp  = e.mb;
                if (e.lat) begin
                    checks++;
                    if (cyc != last_wr_cyc + 1) begin
                        errors++;
                        $display("FAIL done_latency: done at cycle %0d, required %0d",
                                 cyc, last_wr_cyc + 1);
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        bit b;
        cyc++;
        if (mb_pend) begin
            mb_pend = 0;
            checks++;
            if (main_bytes != 11'(mb_exp)) begin
                errors++;
                $display("FAIL main_bytes: got %0d, required %0d", main_bytes, mb_exp);
            end
        end
        if (fifo_wr_en) begin
            wr_count++;
            last_wr_cyc = cyc;
            checks++;
            if (fifo_full) begin
                errors++;
                $display("FAIL wr_while_full: fifo_wr_en=1 with fifo_full=1, required 0");
            end
            checks++;
            if (exp_bits.size() == 0) begin
                errors++;
                $display("FAIL bit_write: got write of %b, required no write", fifo_din);
            end else begin
                b = exp_bits.pop_front();
                if (fifo_din != b) begin
                    errors++;
                    $display("FAIL bit_value: got %b, required %b", fifo_din, b);
                end
            end
        end
        if (frame_abort) see_ev(3);
        if (frame_err)   see_ev(2);
        if (frame_done)  see_ev(1);
    end

    task automatic start_frame(input int fb, input bit m, input bit c, input bit exp_abort);
        int ovh;
        ovh = 4 + (c ? 2 : 0) + (m ? 17 : 32);
        if (exp_abort) push_ev(3, 0, 0);
        if (fb < ovh) push_ev(2, 0, 0);
        frame_start = 1;
        frame_bytes = 11'(fb);
        mono        = m;
        crc_present = c;
        @(negedge clk);
        checks++;
        if (byte_ready) begin
            errors++;
            $display("FAIL ready_in_start: got %b, required 0", byte_ready);
        end
        @(posedge clk);
        #1;
        frame_start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1;
        @(negedge clk);
        while (!byte_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!byte_ready) begin
            errors++;
            $display("FAIL send_timeout: byte %h byte_ready=%b, required 1", b, byte_ready);
        end
        @(posedge clk);
        #1;
        byte_valid = 0;
    endtask

    task automatic send_skip(input int n);
        for (int i = 0; i < n; i++) send_byte(8'(i));
    endtask

    task automatic send_main(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
        send_byte(b);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_ev.size() != 0 || exp_bits.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_ev.size() != 0 || exp_bits.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d events %0d bits pending, required 0 0",
                     exp_ev.size(), exp_bits.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        checks++;
        if (byte_ready || fifo_wr_en || frame_done || frame_err || frame_abort
            || main_bytes != 11'd0) begin
            errors++;
            $display("FAIL %s: rdy=%b wr=%b done=%b err=%b abort=%b mb=%0d, required all 0",
                     tag, byte_ready, fifo_wr_en, frame_done, frame_err, frame_abort,
                     main_bytes);
        end
    endtask

    initial begin
        int w0;
        rst         = 1;
        frame_start = 0;
        frame_bytes = 0;
        mono        = 0;
        crc_present = 0;
        byte_in     = 0;
        byte_valid  = 0;
        #2;
        check_quiet("reset_state");
        @(posedge clk);
        #1;
        rst = 0;
        @(posedge clk);
        #1;

        // Stereo, no CRC, 40 bytes: 36 skipped, 0x24..0x27 serialised.
        push_ev(1, 4, 1);
        start_frame(40, 0, 0, 0);
        send_skip(36);
        for (int k = 0; k < 4; k++) send_main(8'(8'h24 + k));
        wait_idle();

        // Mono, CRC, frame exactly overhead: no main data.
        push_ev(1, 0, 0);
        start_frame(23, 1, 1, 0);
        send_skip(23);
        wait_idle();

        // Short frame: error, byte_ready stays low.
        start_frame(20, 0, 0, 0);
        byte_in    = 8'h55;
        byte_valid = 1;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (byte_ready) begin
                errors++;
                $display("FAIL err_ready: got %b, required 0", byte_ready);
            end
        end
        @(posedge clk);
        #1;
        byte_valid = 0;
        wait_idle();

        // Backpressure: fifo_full toggles every cycle.
        bp_en = 1;
        push_ev(1, 2, 1);
        start_frame(38, 0, 0, 0);
        send_skip(36);
        send_main(8'hA5);
        w0 = wr_count;
        send_main(8'h3C);
        checks++;
        if (wr_count - w0 != 8) begin
            errors++;
            $display("FAIL next_accept: %0d bits written before next load, required 8",
                     wr_count - w0);
        end
        wait_idle();
        bp_en = 0;
        repeat (2) @(posedge clk);
        #1;

        // Abort after 3 bits of 0xC6, then a clean mono+CRC frame with 2 main bytes.
        start_frame(40, 0, 0, 0);
        send_skip(36);
        exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b0);
        w0 = wr_count;
        send_byte(8'hC6);
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            if (wr_count >= w0 + 3) break;
        end
        #1;
        checks++;
        if (wr_count != w0 + 3) begin
            errors++;
            $display("FAIL abort_setup: got %0d writes, required 3", wr_count - w0);
        end
        start_frame(25, 1, 1, 1);
        push_ev(1, 2, 1);
        send_skip(23);
        send_main(8'h5A);
        send_main(8'h0F);
        wait_idle();

        // Asynchronous reset mid-MAIN.
        start_frame(38, 0, 0, 0);
        send_skip(36);
        send_main(8'hFF);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        check_quiet("async_reset");
        exp_bits.delete();
        exp_ev.delete();
        mb_pend = 0;
        @(posedge clk);
        #1;
        rst = 0;
        @(posedge clk);
        #1;
        push_ev(1, 1, 1);
        start_frame(22, 1, 0, 0);
        send_skip(21);
        send_main(8'h81);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
